// File: rtl/fma_pkg.sv
// Shared definitions for the FMA pipeline: opcodes, rounding modes and the
// decoded datapath sign/substitution controls.
package fma_pkg;

    localparam logic [2:0] OP_FMADD  = 3'd0;
    localparam logic [2:0] OP_FMSUB  = 3'd1;
    localparam logic [2:0] OP_FNMSUB = 3'd2;
    localparam logic [2:0] OP_FNMADD = 3'd3;
    localparam logic [2:0] OP_FMUL   = 3'd4;
    localparam logic [2:0] OP_FADD   = 3'd5;
    localparam logic [2:0] OP_FSUB   = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    typedef struct packed {
        logic neg_prod;
        logic neg_addend;
        logic force_one;
        logic force_zero;
    } dec_ctrl_t;

    function automatic logic op_is_reserved(input logic [2:0] op);
        return op == OP_RSVD;
    endfunction

endpackage

// File: rtl/fma_op_decode.sv
// Combinational opcode decode into datapath controls; shared with the issue logic.
module fma_op_decode
    import fma_pkg::*;
(
    input  logic [2:0] op_i,
    output dec_ctrl_t  ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = '0;
        illegal_o = op_is_reserved(op_i);
        case (op_i)
            OP_FMADD:  ctrl_o = '0;
            OP_FMSUB:  ctrl_o.neg_addend = 1'b1;
            OP_FNMSUB: ctrl_o.neg_prod   = 1'b1;
            OP_FNMADD: begin
                ctrl_o.neg_prod   = 1'b1;
                ctrl_o.neg_addend = 1'b1;
            end
            OP_FMUL:   ctrl_o.force_zero = 1'b1;
            OP_FADD:   ctrl_o.force_one  = 1'b1;
            OP_FSUB: begin
                ctrl_o.force_one  = 1'b1;
                ctrl_o.neg_addend = 1'b1;
            end
            default:   ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/fma_pipe_ctrl.sv
// Pipeline controller for the FMA datapath: per-stage valid/tag/rm tracking,
// register enables, back-pressure with bubble collapse, and flush.
module fma_pipe_ctrl
    import fma_pkg::*;
#(
    parameter int PARM_STAGES = 3,
    parameter int PARM_TAG    = 5,
    parameter int PARM_RM     = 3
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [2:0]                         op_i,
    input  logic [PARM_RM-1:0]                 rm_i,
    input  logic [PARM_TAG-1:0]                tag_i,
    input  logic                               flush_i,
    output logic [PARM_STAGES-1:0]             stage_en_o,
    output logic                               neg_prod_o,
    output logic                               neg_addend_o,
    output logic                               force_one_o,
    output logic                               force_zero_o,
    output logic                               illegal_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [PARM_TAG-1:0]                out_tag_o,
    output logic [PARM_RM-1:0]                 out_rm_o,
    output logic [$clog2(PARM_STAGES+1)-1:0]   occupancy_o,
    output logic                               busy_o
);

    localparam int LAST  = PARM_STAGES - 1;
    localparam int OCC_W = $clog2(PARM_STAGES + 1);

    logic [PARM_STAGES-1:0] v;
    logic [PARM_STAGES-1:0] adv;
    logic [PARM_TAG-1:0]    tag_q [PARM_STAGES];
    logic [PARM_RM-1:0]     rm_q  [PARM_STAGES];
    dec_ctrl_t              dec_q;
    logic                   illegal_q;

    dec_ctrl_t dec;
    logic      dec_illegal;
    logic      accept;

    fma_op_decode u_dec (
        .op_i      (op_i),
        .ctrl_o    (dec),
        .illegal_o (dec_illegal)
    );

    // A stage advances when its successor is empty or itself advancing, so
    // bubbles close up even while the last stage is stalled.
    always_comb begin
        adv       = '0;
        adv[LAST] = v[LAST] & out_ready_i;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = v[k] & (~v[k+1] | adv[k+1]);
        end
    end

    assign in_ready_o = rst_ni & ~flush_i & (~v[0] | adv[0]);
    assign accept     = in_valid_i & in_ready_o;

    always_comb begin
        stage_en_o    = '0;
        stage_en_o[0] = accept;
        for (int k = 1; k < PARM_STAGES; k++) begin
            stage_en_o[k] = v[k-1] & adv[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v         <= '0;
            dec_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept & dec_illegal;
            if (accept) begin
                dec_q <= dec;
            end
            if (flush_i) begin
                v <= '0;
            end else begin
                // Reserved ops are consumed but never occupy a stage.
                v[0] <= (accept & ~dec_illegal) | (v[0] & ~adv[0]);
                for (int k = 1; k < PARM_STAGES; k++) begin
                    v[k] <= adv[k-1] | (v[k] & ~adv[k]);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < PARM_STAGES; k++) begin
                tag_q[k] <= '0;
                rm_q[k]  <= '0;
            end
        end else begin
            if (stage_en_o[0]) begin
                tag_q[0] <= tag_i;
                rm_q[0]  <= rm_i;
            end
            for (int k = 1; k < PARM_STAGES; k++) begin
                if (stage_en_o[k]) begin
                    tag_q[k] <= tag_q[k-1];
                    rm_q[k]  <= rm_q[k-1];
                end
            end
        end
    end

    always_comb begin
        occupancy_o = '0;
        for (int k = 0; k < PARM_STAGES; k++) begin
            occupancy_o = occupancy_o + OCC_W'(v[k]);
        end
    end

    assign busy_o       = |v;
    assign out_valid_o  = v[LAST];
    assign out_tag_o    = tag_q[LAST];
    assign out_rm_o     = rm_q[LAST];
    assign neg_prod_o   = dec_q.neg_prod;
    assign neg_addend_o = dec_q.neg_addend;
    assign force_one_o  = dec_q.force_one;
    assign force_zero_o = dec_q.force_zero;
    assign illegal_o    = illegal_q;

endmodule
